// File: rtl/alu_mult_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mult_unit_if
//  Description : Handshake and data bundle between the control unit / operand
//                path and the sequential multiplier.
//                master : drives start, signed_mode, operand1, operand2
//                slave  : drives result, result_full, overflow, busy, done
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_mult_unit_if #(
    parameter int WIDTH = 8
);
    logic                   start;        // request, sampled only while idle
    logic                   signed_mode;  // 1 = two's-complement operands
    logic [WIDTH-1:0]       operand1;     // multiplicand
    logic [WIDTH-1:0]       operand2;     // multiplier
    logic [WIDTH-1:0]       result;       // low half of the product
    logic [2*WIDTH-1:0]     result_full;  // full product
    logic                   overflow;     // product does not fit in WIDTH bits
    logic                   busy;         // operation in flight
    logic                   done;         // one-cycle completion pulse

    modport master (
        output start, signed_mode, operand1, operand2,
        input  result, result_full, overflow, busy, done
    );

    modport slave (
        input  start, signed_mode, operand1, operand2,
        output result, result_full, overflow, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/alu_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mult_unit
//  Description : Sequential WIDTH x WIDTH shift-add multiplier. Operands are
//                reduced to magnitudes on acceptance, multiplied LSB-first one
//                bit per cycle, and the sign is restored in a final fix-up
//                cycle.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - alu_mult_unit_if.slave (start/signed_mode/operands
//                         in; result/result_full/overflow/busy/done out)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mult_unit #(
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_mult_unit_if.slave   bus
);

    // Counter must be able to hold 0..WIDTH.
    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;

    logic [WIDTH-1:0]       r_mag1;
    logic [WIDTH-1:0]       r_mag2;
    logic                   r_neg;
    logic                   r_signed;
    logic [2*WIDTH-1:0]     r_acc;
    logic [c_CNT_W-1:0]     r_count;
    logic [WIDTH-1:0]       r_result;
    logic [2*WIDTH-1:0]     r_result_full;
    logic                   r_overflow;
    logic                   r_busy;
    logic                   r_done;

    logic [WIDTH-1:0]       w_mag1_in;
    logic [WIDTH-1:0]       w_mag2_in;
    logic [2*WIDTH-1:0]     w_addend;
    logic [2*WIDTH-1:0]     w_full;
    logic                   w_overflow;

    // Magnitude of each operand. 0x80 maps onto itself, which read unsigned
    // is exactly 128, so the most negative value needs no special case.
    assign w_mag1_in = (bus.signed_mode && bus.operand1[WIDTH-1]) ?
                       (~bus.operand1 + 1'b1) : bus.operand1;
    assign w_mag2_in = (bus.signed_mode && bus.operand2[WIDTH-1]) ?
                       (~bus.operand2 + 1'b1) : bus.operand2;

    // Partial product for the current multiplier bit.
    assign w_addend = {{WIDTH{1'b0}}, r_mag1} << r_count;

    // Sign correction and overflow classification of the finished product.
    assign w_full = r_neg ? (~r_acc + 1'b1) : r_acc;

    always_comb begin
        w_overflow = 1'b0;
        if (r_signed) begin
            w_overflow = (w_full != {{WIDTH{w_full[WIDTH-1]}}, w_full[WIDTH-1:0]});
        end else begin
            w_overflow = |w_full[2*WIDTH-1:WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_CALC;
                    w_accept    = 1'b1;
                end
            end
            S_CALC: begin
                // The step taken with count == WIDTH-1 is the last one.
                if (r_count == c_LAST) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag1        <= '0;
            r_mag2        <= '0;
            r_neg         <= 1'b0;
            r_signed      <= 1'b0;
            r_acc         <= '0;
            r_count       <= '0;
            r_result      <= '0;
            r_result_full <= '0;
            r_overflow    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // DONE lasts one cycle; a start in that same cycle is
                    // accepted here and also clears it.
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_mag1   <= w_mag1_in;
                        r_mag2   <= w_mag2_in;
                        r_neg    <= bus.signed_mode &
                                    (bus.operand1[WIDTH-1] ^ bus.operand2[WIDTH-1]);
                        r_signed <= bus.signed_mode;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (r_mag2[0]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_mag2  <= r_mag2 >> 1;
                    r_count <= r_count + 1'b1;
                end
                S_FIX: begin
                    r_result_full <= w_full;
                    r_result      <= w_full[WIDTH-1:0];
                    r_overflow    <= w_overflow;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b1;
                end
                default: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result      = r_result;
    assign bus.result_full = r_result_full;
    assign bus.overflow    = r_overflow;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mult_unit
//  Description : Self-checking bench for alu_mult_unit. Expected products
//                come from plain integer multiplication of the operands.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_mult_unit;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_mult_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_mult_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer product of the operands as numbers.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  input logic s, output logic [15:0] full,
                                  output logic ov);
        int p;
        if (s) p = int'($signed(a)) * int'($signed(b));
        else   p = int'(a) * int'(b);
        full = p[15:0];
        ov   = s ? ((p < -128) || (p > 127)) : (p > 255);
    endfunction

    // Drive a request for one edge; caller positions us before the edge.
    // Operands are scrambled right after acceptance.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        bus.start       = 1'b1;
        bus.operand1    = a;
        bus.operand2    = b;
        bus.signed_mode = s;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.operand1    = 8'($urandom);
        bus.operand2    = 8'($urandom);
        bus.signed_mode = 1'($urandom);
    endtask

    // Waits (bounded) for DONE, sampling on falling edges.
    task automatic wait_done(input int max_cycles, output int busy_cycles,
                             output bit timeout, output bit res_changed,
                             output bit both_high);
        logic [15:0] snap;
        snap        = bus.result_full;
        busy_cycles = 0;
        timeout     = 1'b1;
        res_changed = 1'b0;
        both_high   = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus.busy && bus.done) both_high = 1'b1;
            if (bus.done) begin
                timeout = 1'b0;
                break;
            end
            if (bus.busy) busy_cycles++;
            if (bus.result_full !== snap) res_changed = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.operand1    = '0;
        bus.operand2    = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.result_full, bus.result, bus.overflow, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got full=%h res=%h ov=%b busy=%b done=%b, want all 0",
                     bus.result_full, bus.result, bus.overflow, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one operation and checks it fully against the model.
    task automatic check_op(input string name, input logic [7:0] a,
                            input logic [7:0] b, input logic s);
        logic [15:0] exp_full;
        logic        exp_ov;
        int          bc;
        bit          to, rc, bh;
        model(a, b, s, exp_full, exp_ov);
        @(negedge clk);
        start_op(a, b, s);
        wait_done(30, bc, to, rc, bh);
        n_checks++;
        if (to || bus.result_full !== exp_full || bus.result !== exp_full[7:0] ||
            bus.overflow !== exp_ov) begin
            n_fail++;
            $display("FAIL %s: a=%h b=%h s=%b timeout=%b got full=%h res=%h ov=%b, want full=%h res=%h ov=%b",
                     name, a, b, s, to, bus.result_full, bus.result, bus.overflow,
                     exp_full, exp_full[7:0], exp_ov);
        end
        n_checks++;
        if (bc !== 9 || rc || bh) begin
            n_fail++;
            $display("FAIL %s_timing: busy_cycles=%0d res_changed=%b busy_and_done=%b, want 9/0/0",
                     name, bc, rc, bh);
        end
    endtask

    task automatic test_unsigned();
        check_op("u_7x6", 8'd7, 8'd6, 1'b0);
        n_checks++;
        if (bus.result_full !== 16'h002A || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL u_7x6_const: got %h ov=%b, want 002a ov=0", bus.result_full, bus.overflow);
        end
        check_op("u_fdx05", 8'hFD, 8'h05, 1'b0);
        n_checks++;
        if (bus.result_full !== 16'h04F1 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL u_fdx05_const: got %h ov=%b, want 04f1 ov=1", bus.result_full, bus.overflow);
        end
    endtask

    task automatic test_signed();
        check_op("s_fdx05", 8'hFD, 8'h05, 1'b1);
        n_checks++;
        if (bus.result_full !== 16'hFFF1 || bus.result !== 8'hF1 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL s_fdx05_const: got %h/%h ov=%b, want fff1/f1 ov=0",
                     bus.result_full, bus.result, bus.overflow);
        end
        check_op("s_neg_neg", 8'hF6, 8'hF3, 1'b1);
        check_op("s_pos_neg", 8'h0B, 8'hFE, 1'b1);
    endtask

    task automatic test_corner();
        check_op("s_80x80", 8'h80, 8'h80, 1'b1);
        n_checks++;
        if (bus.result_full !== 16'h4000 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL s_80x80_const: got %h ov=%b, want 4000 ov=1", bus.result_full, bus.overflow);
        end
        check_op("u_ffxff", 8'hFF, 8'hFF, 1'b0);
        n_checks++;
        if (bus.result_full !== 16'hFE01 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL u_ffxff_const: got %h ov=%b, want fe01 ov=1", bus.result_full, bus.overflow);
        end
        check_op("s_80x7f", 8'h80, 8'h7F, 1'b1);
        check_op("zero", 8'h00, 8'h9C, 1'b1);
        check_op("s_minus1", 8'hFF, 8'h80, 1'b1);
    endtask

    task automatic test_busy_ignore();
        int bc, dones;
        bit to, rc, bh;
        @(negedge clk);
        start_op(8'd3, 8'd4, 1'b0);
        repeat (2) @(negedge clk);
        start_op(8'd9, 8'd9, 1'b0);
        wait_done(30, bc, to, rc, bh);
        n_checks++;
        if (to || bus.result_full !== 16'h000C) begin
            n_fail++;
            $display("FAIL busy_ignore_result: timeout=%b got %h, want 000c", to, bus.result_full);
        end
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL busy_ignore_single_done: extra busy/done cycles=%0d, want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        bit to, rc, bh;
        @(negedge clk);
        start_op(8'd3, 8'd4, 1'b0);
        wait_done(30, bc, to, rc, bh);
        // Now sitting in the DONE cycle: request immediately.
        start_op(8'd2, 8'd2, 1'b0);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got done=%b busy=%b, want done=0 busy=1", bus.done, bus.busy);
        end
        wait_done(30, bc, to, rc, bh);
        n_checks++;
        if (to || bus.result_full !== 16'h0004 || bc !== 9) begin
            n_fail++;
            $display("FAIL b2b_result: timeout=%b got %h busy=%0d, want 0004 busy=9",
                     to, bus.result_full, bc);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        @(negedge clk);
        start_op(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.result_full, bus.result, bus.overflow, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got full=%h busy=%b done=%b, want all 0",
                     bus.result_full, bus.busy, bus.done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL async_reset_no_done: busy/done cycles=%0d, want 0", seen);
        end
        check_op("after_reset", 8'h12, 8'h34, 1'b0);
        n_checks++;
        if (bus.result_full !== 16'h03A8) begin
            n_fail++;
            $display("FAIL after_reset_const: got %h, want 03a8", bus.result_full);
        end
    endtask

    task automatic test_hold();
        int bad;
        check_op("hold_5x5", 8'd5, 8'd5, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.operand1    = 8'($urandom);
            bus.operand2    = 8'($urandom);
            bus.signed_mode = 1'($urandom);
            @(negedge clk);
            if (bus.result !== 8'h19 || bus.result_full !== 16'h0019 || bus.done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold: %0d cycles deviated (now res=%h done=%b), want res=19 done=0",
                     bad, bus.result, bus.done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            check_op("random", 8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_corner();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        test_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mult_unit.md
Name: alu_mult_unit

Overview:
Sequential 8x8 multiplier in the extended-ISA datapath. It sits directly downstream of the negation stage and consumes the operand after the complement/select mux. It produces an 8-bit result for the register-file writeback and a 16-bit full product. Signed operation reuses two's-complement negation: magnitudes are multiplied, then the sign is corrected. A start/busy/done handshake lets the control unit stall the pipeline for the duration.

Parameters:
WIDTH, 8, operand width; full product is 2*WIDTH bits; the step counter covers 0..WIDTH.

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-low reset (0 = reset asserted)
START  input  1  request; sampled on a rising edge only while IDLE
SIGNED_MODE  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START
OPERAND1  input  WIDTH  multiplicand (DATA1 from the register file)
OPERAND2  input  WIDTH  multiplier (output of the complement/select mux)
RESULT  output  WIDTH  low WIDTH bits of the product, registered
RESULT_FULL  output  2*WIDTH  full product, registered
OVERFLOW  output  1  product does not fit in WIDTH bits (signed or unsigned, per mode)
BUSY  output  1  high from the accept edge until the completion edge
DONE  output  1  one-cycle pulse; results are valid from this cycle onward

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; RESULT, RESULT_FULL, OVERFLOW, BUSY, DONE, accumulator, counter and all internal registers = 0.
- States:
  - IDLE -> CALC on an edge with START=1.
  - CALC -> CALC while counter < WIDTH-1; CALC -> FIX on the WIDTH-th step.
  - FIX -> IDLE.
- Accept edge (IDLE, START=1):
  - Latch mag1 and mag2. In signed mode, mag = bitwise invert + 1 when the MSB is 1; otherwise mag = operand.
  - Latch neg = SIGNED_MODE & (OPERAND1[MSB] ^ OPERAND2[MSB]).
  - Clear the 2*WIDTH accumulator; counter=0; BUSY=1; DONE=0.
- CALC, one step per edge (LSB-first shift-add):
  - If mag2[0], acc = acc + (mag1 << counter).
  - mag2 >>= 1; counter++.
  - Exactly WIDTH steps.
- FIX edge:
  - RESULT_FULL = neg ? (~acc + 1) : acc; RESULT = RESULT_FULL[WIDTH-1:0].
  - OVERFLOW, signed mode: RESULT_FULL is not the sign extension of RESULT.
  - OVERFLOW, unsigned mode: RESULT_FULL[2W-1:W] is nonzero.
  - DONE=1, BUSY=0.
- Latency (WIDTH=8): accept at edge n; DONE and results are visible after edge n+9; DONE falls after edge n+10.
- BUSY and DONE are never high together.
- START while BUSY is ignored; the operation in flight is unaffected and no request is queued.
- START high in the DONE cycle is accepted: DONE clears and a new operation begins on that edge.
- RESULT, RESULT_FULL and OVERFLOW hold their values until the next FIX edge or reset. They do not change while BUSY.
- Operand inputs may change after the accept edge with no effect on the operation in flight.
- A magnitude of -2^(W-1) (0x80) is 128 unsigned and is handled correctly. The signed product range [-16256, 16384] fits in 16 bits.
- Zero operands still take the full WIDTH steps; there is no early termination.
- RESET asserted mid-operation aborts immediately: state returns to IDLE, all outputs read 0, and no DONE pulse is produced.

Test Plan:
1. Unsigned 7 x 6 -> after 9 edges DONE=1, RESULT_FULL=0x002A, RESULT=0x2A, OVERFLOW=0; BUSY was high for exactly 9 cycles.
2. 0xFD x 0x05: unsigned -> 0x04F1, OVERFLOW=1; signed -> 0xFFF1 (-15), RESULT=0xF1, OVERFLOW=0.
3. Signed 0x80 x 0x80 -> 0x4000, OVERFLOW=1. Unsigned 0xFF x 0xFF -> 0xFE01, OVERFLOW=1.
4. Start 3 x 4, then pulse START with 9 x 9 at cycle 3 -> result 0x000C, one DONE only. Then START in the DONE cycle with 2 x 2 -> DONE clears and the next DONE gives 0x0004.
5. Start 0x12 x 0x34, assert RESET at cycle 4 -> outputs 0 immediately, no DONE. Release reset, run 0x12 x 0x34 -> 0x03A8.
6. Complete 5 x 5 (0x0019), then hold START=0 for 20 cycles while changing operands -> RESULT stays 0x19 and DONE stays 0.
